// File: rtl/io_uart_in_pkg.sv
// io_uart_in_pkg
//   Shared constants for the UART receive block: default register word
//   addresses, status-word bit positions and a helper that packs the
//   status word.
//   Optional feature macro used by the block: IO_UART_IN_IRQ_EN.
package io_uart_in_pkg;

   // Default word addresses (byte address bits [15:2]).
   localparam logic [13:0] RX_DATA_ADR_DEF = 14'h3E02;
   localparam logic [13:0] RX_STAT_ADR_DEF = 14'h3E03;

   // Status word layout.
   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_OVERRUN   = 1;
   localparam int STAT_IRQ_EN    = 2;
   localparam int STAT_COUNT_LSB = 8;
   localparam int STAT_COUNT_W   = 5;

   function automatic logic [31:0] status_word(
      input logic       not_empty,
      input logic       overrun,
      input logic       irq_enable,
      input logic [4:0] count
   );
      logic [31:0] w;
      w = '0;
      w[STAT_NOT_EMPTY] = not_empty;
      w[STAT_OVERRUN]   = overrun;
      w[STAT_IRQ_EN]    = irq_enable;
      w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
      return w;
   endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// io_rx_fifo
//   Synchronous byte FIFO, depth 2**AW, storage in an inferred RAM with a
//   registered read port.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     push, push_data   write one byte (accepted if not full, or if a pop
//                       happens in the same cycle)
//     pop               remove the oldest byte (ignored when empty)
//     pop_data          byte removed by the previous cycle's pop
//     full, empty       occupancy flags (combinational from count)
//     count             number of stored bytes, 0..2**AW
module io_rx_fifo #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 2**AW;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [7:0]    pop_data_reg;
   logic          do_push;
   logic          do_pop;

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign pop_data = pop_data_reg;

   assign do_pop  = pop & ~empty & ~rst;
   // A pop in the same cycle frees a slot, so a push at full is still taken.
   assign do_push = push & (~full | do_pop) & ~rst;

   // RAM write port, kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Registered read. At full with push+pop the pointers coincide; the read
   // sees the old contents, which is the oldest byte as intended.
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_data_reg <= '0;
      end else if (do_pop) begin
         pop_data_reg <= mem[rd_ptr_reg];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/io_uart_in.sv
// io_uart_in
//   UART receive side as an IO-bus peripheral: received bytes go into a
//   FIFO which the CPU drains through a data register; a status/control
//   register reports occupancy and a sticky overrun flag.
//   Optional feature macro: IO_UART_IN_IRQ_EN (irq_enable bit and level
//   interrupt; without it interrupt_rx is 0 and status bit2 reads 0).
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     dma_io_we/wadr/wdata             CPU IO write
//     dma_io_radr/radr_en              CPU IO read request
//     dma_io_rdata_in / dma_io_rdata   read-data chain in / out (hits are
//                                      returned one cycle after the request)
//     uart_in_char, uart_in_we         received byte strobe
//     uart_in_full                     FIFO full
//     interrupt_rx                     level RX interrupt (registered)
module io_uart_in
   import io_uart_in_pkg::*;
#(
   parameter int          FIFO_AW     = 4,
   parameter logic [13:0] RX_DATA_ADR = RX_DATA_ADR_DEF,
   parameter logic [13:0] RX_STAT_ADR = RX_STAT_ADR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [31:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic        dma_io_radr_en,
   input  logic [31:0] dma_io_rdata_in,
   output logic [31:0] dma_io_rdata,
   input  logic [7:0]  uart_in_char,
   input  logic        uart_in_we,
   output logic        uart_in_full,
   output logic        interrupt_rx
);

   // Bits of count that fit in the status count field.
   localparam int CW = (FIFO_AW + 1 < STAT_COUNT_W) ? FIFO_AW + 1 : STAT_COUNT_W;

   logic              data_hit;
   logic              stat_hit;
   logic              stat_wr;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_AW:0]  fifo_count;
   logic [7:0]        fifo_pop_data;
   logic [4:0]        count5;
   logic              irq_enable;

   logic              overrun_reg;
   logic              hit_reg;
   logic              data_sel_reg;
   logic              data_valid_reg;
   logic [31:0]       stat_reg;

   assign data_hit = dma_io_radr_en && (dma_io_radr == RX_DATA_ADR);
   assign stat_hit = dma_io_radr_en && (dma_io_radr == RX_STAT_ADR);
   assign stat_wr  = dma_io_we && (dma_io_wadr == RX_STAT_ADR);
   // Full implies not empty, so a data read always frees a slot here.
   assign drop     = uart_in_we & fifo_full & ~data_hit;
   assign count5   = 5'(fifo_count[CW-1:0]);

   io_rx_fifo #(
      .AW (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (uart_in_we),
      .push_data (uart_in_char),
      .pop       (data_hit),
      .pop_data  (fifo_pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign uart_in_full = fifo_full;

   // Sticky overrun; a dropped byte wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_reg <= 1'b0;
      end else if (drop) begin
         overrun_reg <= 1'b1;
      end else if (stat_wr && dma_io_wdata[STAT_OVERRUN]) begin
         overrun_reg <= 1'b0;
      end
   end

`ifdef IO_UART_IN_IRQ_EN
   logic irq_enable_reg;
   logic irq_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_enable_reg <= 1'b0;
         irq_reg        <= 1'b0;
      end else begin
         if (stat_wr) begin
            irq_enable_reg <= dma_io_wdata[STAT_IRQ_EN];
         end
         irq_reg <= irq_enable_reg & (~fifo_empty | overrun_reg);
      end
   end

   assign irq_enable   = irq_enable_reg;
   assign interrupt_rx = irq_reg;

   logic unused_wdata;
   assign unused_wdata = ^{dma_io_wdata[31:3], dma_io_wdata[0]};
`else
   assign irq_enable   = 1'b0;
   assign interrupt_rx = 1'b0;

   logic unused_wdata;
   assign unused_wdata = ^{dma_io_wdata[31:2], dma_io_wdata[0]};
`endif

   // Read side: capture what the hit returns; the data byte itself comes
   // from the FIFO's registered read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_reg        <= 1'b0;
         data_sel_reg   <= 1'b0;
         data_valid_reg <= 1'b0;
         stat_reg       <= '0;
      end else begin
         hit_reg        <= data_hit | stat_hit;
         data_sel_reg   <= data_hit;
         data_valid_reg <= data_hit & ~fifo_empty;
         stat_reg       <= stat_hit
                           ? status_word(~fifo_empty, overrun_reg, irq_enable, count5)
                           : '0;
      end
   end

   always_comb begin
      dma_io_rdata = dma_io_rdata_in;
      if (hit_reg) begin
         if (data_sel_reg) begin
            dma_io_rdata = data_valid_reg ? {24'd0, fifo_pop_data} : 32'd0;
         end else begin
            dma_io_rdata = stat_reg;
         end
      end
   end

endmodule

// File: tb/tb_io_uart_in.sv
// tb_io_uart_in
//   Self-checking bench for io_uart_in (FIFO_AW = 4). A queue-based model
//   of the receive FIFO, overrun flag and irq enable predicts every read.
module tb_io_uart_in;

   localparam int          FIFO_AW = 4;
   localparam int          DEPTH   = 16;
   localparam logic [13:0] DATA_A  = 14'h3E02;
   localparam logic [13:0] STAT_A  = 14'h3E03;

   logic        clk = 1'b0;
   logic        rst;
   logic        dma_io_we;
   logic [15:2] dma_io_wadr;
   logic [31:0] dma_io_wdata;
   logic [15:2] dma_io_radr;
   logic        dma_io_radr_en;
   logic [31:0] dma_io_rdata_in;
   logic [31:0] dma_io_rdata;
   logic [7:0]  uart_in_char;
   logic        uart_in_we;
   logic        uart_in_full;
   logic        interrupt_rx;

   int checks = 0;
   int passed = 0;

   // Reference model state
   logic [7:0] q[$];
   bit         m_ovr;
   bit         m_irq;

   always #5 clk = ~clk;

   io_uart_in #(
      .FIFO_AW (FIFO_AW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .dma_io_we       (dma_io_we),
      .dma_io_wadr     (dma_io_wadr),
      .dma_io_wdata    (dma_io_wdata),
      .dma_io_radr     (dma_io_radr),
      .dma_io_radr_en  (dma_io_radr_en),
      .dma_io_rdata_in (dma_io_rdata_in),
      .dma_io_rdata    (dma_io_rdata),
      .uart_in_char    (uart_in_char),
      .uart_in_we      (uart_in_we),
      .uart_in_full    (uart_in_full),
      .interrupt_rx    (interrupt_rx)
   );

   function automatic logic [31:0] m_status();
      logic [4:0] c;
      c = 5'(q.size());
      return {19'd0, c, 5'd0, m_irq, m_ovr, (q.size() != 0)};
   endfunction

   function automatic bit m_irq_out();
      return m_irq && ((q.size() != 0) || m_ovr);
   endfunction

   task automatic model_clear();
      q.delete();
      m_ovr = 0;
      m_irq = 0;
   endtask

   // One bus cycle: drive at negedge, update model, return at posedge+1
   // with the expected dma_io_rdata for that sample point.
   task automatic step(input bit we_u, input logic [7:0] ch,
                       input bit rd, input logic [13:0] ra,
                       input bit wr, input logic [13:0] wa, input logic [31:0] wd,
                       output logic [31:0] exp_rd);
      bit drop;
      drop = 0;
      @(negedge clk);
      uart_in_we     = we_u;
      uart_in_char   = ch;
      dma_io_radr_en = rd;
      dma_io_radr    = ra;
      dma_io_we      = wr;
      dma_io_wadr    = wa;
      dma_io_wdata   = wd;
      if (rd && ra == DATA_A) begin
         if (q.size() != 0) exp_rd = {24'd0, q.pop_front()};
         else               exp_rd = 32'd0;
      end else if (rd && ra == STAT_A) begin
         exp_rd = m_status();
      end else begin
         exp_rd = dma_io_rdata_in;
      end
      if (we_u) begin
         if (q.size() < DEPTH) q.push_back(ch);
         else                  drop = 1;
      end
      if (wr && wa == STAT_A) begin
`ifdef IO_UART_IN_IRQ_EN
         m_irq = wd[2];
`endif
         if (wd[1]) m_ovr = 0;
      end
      if (drop) m_ovr = 1;
      @(posedge clk);
      #1;
      uart_in_we     = 0;
      dma_io_radr_en = 0;
      dma_io_we      = 0;
   endtask

   task automatic push(input logic [7:0] ch);
      logic [31:0] e;
      step(1, ch, 0, 14'h0, 0, 14'h0, 32'h0, e);
   endtask

   task automatic idle(input int n);
      logic [31:0] e;
      for (int i = 0; i < n; i++) step(0, 8'h0, 0, 14'h0, 0, 14'h0, 32'h0, e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_clear();
   endtask

   task automatic test_reset();
      logic [31:0] e;
      dma_io_rdata_in = 32'h1234_5678;
      do_reset();
      #1;
      checks++; if (dma_io_rdata !== 32'h1234_5678) $display("FAIL reset_rdata got %h want %h", dma_io_rdata, 32'h1234_5678); else passed++;
      checks++; if (uart_in_full !== 1'b0) $display("FAIL reset_full got %b want 0", uart_in_full); else passed++;
      checks++; if (interrupt_rx !== 1'b0) $display("FAIL reset_irq got %b want 0", interrupt_rx); else passed++;
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0) $display("FAIL reset_status got %h want %h", dma_io_rdata, 32'h0); else passed++;
   endtask

   task automatic test_basic();
      logic [31:0] e;
      push(8'h41);
      push(8'h42);
      step(0, 0, 1, DATA_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h41) $display("FAIL basic_rd0 got %h want %h", dma_io_rdata, 32'h41); else passed++;
      step(0, 0, 1, DATA_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h42) $display("FAIL basic_rd1 got %h want %h", dma_io_rdata, 32'h42); else passed++;
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0) $display("FAIL basic_status got %h want %h", dma_io_rdata, 32'h0); else passed++;
   endtask

   task automatic test_fill();
      logic [31:0] e;
      for (int i = 0; i < 17; i++) begin
         push(8'h10 + 8'(i));
         if (i == 14) begin
            checks++; if (uart_in_full !== 1'b0) $display("FAIL fill_full15 got %b want 0", uart_in_full); else passed++;
         end
         if (i == 15) begin
            checks++; if (uart_in_full !== 1'b1) $display("FAIL fill_full16 got %b want 1", uart_in_full); else passed++;
         end
      end
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0000_1003) $display("FAIL fill_status got %h want %h", dma_io_rdata, 32'h0000_1003); else passed++;
   endtask

   task automatic test_push_pop_full();
      logic [31:0] e;
      step(0, 0, 0, 0, 1, STAT_A, 32'h2, e);          // clear overrun
      step(1, 8'hAA, 1, DATA_A, 0, 0, 0, e);          // push + pop at full
      checks++; if (dma_io_rdata !== 32'h10) $display("FAIL pp_oldest got %h want %h", dma_io_rdata, 32'h10); else passed++;
      checks++; if (uart_in_full !== 1'b1) $display("FAIL pp_full got %b want 1", uart_in_full); else passed++;
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0000_1001) $display("FAIL pp_status got %h want %h", dma_io_rdata, 32'h0000_1001); else passed++;
   endtask

   task automatic test_overrun_clear();
      logic [31:0] e;
      push(8'hEE);                                    // dropped
      step(0, 0, 0, 0, 1, DATA_A, 32'h2, e);          // write to data reg: ignored
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0000_1003) $display("FAIL ovr_set got %h want %h", dma_io_rdata, 32'h0000_1003); else passed++;
      step(0, 0, 0, 0, 1, STAT_A, 32'h2, e);
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0000_1001) $display("FAIL ovr_clear got %h want %h", dma_io_rdata, 32'h0000_1001); else passed++;
      step(1, 8'hEF, 0, 0, 1, STAT_A, 32'h2, e);      // drop + clear same cycle
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0000_1003) $display("FAIL ovr_priority got %h want %h", dma_io_rdata, 32'h0000_1003); else passed++;
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 1, DATA_A, 0, 0, 0, e);
         checks++; if (dma_io_rdata !== e) $display("FAIL drain_%0d got %h want %h", i, dma_io_rdata, e); else passed++;
      end
      step(0, 0, 0, 0, 1, STAT_A, 32'h2, e);
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0) $display("FAIL drain_status got %h want %h", dma_io_rdata, 32'h0); else passed++;
   endtask

   task automatic test_empty_read();
      logic [31:0] e;
      dma_io_rdata_in = 32'hDEAD_BEEF;
      step(0, 0, 1, DATA_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0) $display("FAIL empty_rd got %h want %h", dma_io_rdata, 32'h0); else passed++;
      push(8'h5A);
      step(0, 0, 1, DATA_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h5A) $display("FAIL empty_noptr got %h want %h", dma_io_rdata, 32'h5A); else passed++;
      idle(1);
      checks++; if (dma_io_rdata !== 32'hDEAD_BEEF) $display("FAIL pass_idle got %h want %h", dma_io_rdata, 32'hDEAD_BEEF); else passed++;
      step(0, 0, 1, 14'h1234, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'hDEAD_BEEF) $display("FAIL pass_other got %h want %h", dma_io_rdata, 32'hDEAD_BEEF); else passed++;
   endtask

   task automatic test_irq();
      logic [31:0] e;
      step(0, 0, 0, 0, 1, STAT_A, 32'h4, e);
      push(8'h33);
      idle(2);
`ifdef IO_UART_IN_IRQ_EN
      checks++; if (interrupt_rx !== 1'b1) $display("FAIL irq_on got %b want 1", interrupt_rx); else passed++;
`else
      checks++; if (interrupt_rx !== 1'b0) $display("FAIL irq_off got %b want 0", interrupt_rx); else passed++;
`endif
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== e) $display("FAIL irq_status got %h want %h", dma_io_rdata, e); else passed++;
      step(0, 0, 1, DATA_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h33) $display("FAIL irq_pop got %h want %h", dma_io_rdata, 32'h33); else passed++;
      idle(2);
      checks++; if (interrupt_rx !== 1'b0) $display("FAIL irq_clear got %b want 0", interrupt_rx); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
      idle(2);
      // Reset together with a push and a write: both must be discarded.
      @(negedge clk);
      rst = 1; uart_in_we = 1; uart_in_char = 8'h99;
      dma_io_we = 1; dma_io_wadr = STAT_A; dma_io_wdata = 32'h4;
      @(posedge clk);
      @(negedge clk);
      rst = 0; uart_in_we = 0; dma_io_we = 0;
      model_clear();
      #1;
      checks++; if (dma_io_rdata !== dma_io_rdata_in) $display("FAIL rstmid_rdata got %h want %h", dma_io_rdata, dma_io_rdata_in); else passed++;
      checks++; if (uart_in_full !== 1'b0) $display("FAIL rstmid_full got %b want 0", uart_in_full); else passed++;
      checks++; if (interrupt_rx !== 1'b0) $display("FAIL rstmid_irq got %b want 0", interrupt_rx); else passed++;
      step(0, 0, 1, STAT_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0) $display("FAIL rstmid_status got %h want %h", dma_io_rdata, 32'h0); else passed++;
      step(0, 0, 1, DATA_A, 0, 0, 0, e);
      checks++; if (dma_io_rdata !== 32'h0) $display("FAIL rstmid_empty got %h want %h", dma_io_rdata, 32'h0); else passed++;
   endtask

   task automatic test_random();
      logic [31:0] e;
      int op;
      for (int i = 0; i < 400; i++) begin
         dma_io_rdata_in = $urandom();
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2, 3: step(1, 8'($urandom()), 0, 0, 0, 0, 0, e);
            4, 5:       step(0, 0, 1, DATA_A, 0, 0, 0, e);
            6:          step(1, 8'($urandom()), 1, DATA_A, 0, 0, 0, e);
            7:          step(0, 0, 1, STAT_A, 0, 0, 0, e);
            8:          step($urandom_range(0, 1) == 1, 8'($urandom()), 0, 0, 1,
                             ($urandom_range(0, 3) == 0) ? DATA_A : STAT_A,
                             $urandom() & 32'h6, e);
            default:    step(0, 0, 1, 14'($urandom()), 0, 0, 0, e);
         endcase
         checks++; if (dma_io_rdata !== e) $display("FAIL rand_rdata_%0d got %h want %h", i, dma_io_rdata, e); else passed++;
         checks++; if (uart_in_full !== (q.size() == DEPTH)) $display("FAIL rand_full_%0d got %b want %b", i, uart_in_full, q.size() == DEPTH); else passed++;
         if (i % 50 == 49) begin
            idle(2);
            checks++; if (interrupt_rx !== m_irq_out()) $display("FAIL rand_irq_%0d got %b want %b", i, interrupt_rx, m_irq_out()); else passed++;
         end
      end
   endtask

   initial begin
      rst = 1;
      dma_io_we = 0; dma_io_wadr = '0; dma_io_wdata = '0;
      dma_io_radr = '0; dma_io_radr_en = 0; dma_io_rdata_in = '0;
      uart_in_char = '0; uart_in_we = 0;
      model_clear();
      test_reset();
      test_basic();
      test_fill();
      test_push_pop_full();
      test_overrun_clear();
      test_empty_read();
      test_irq();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/io_uart_in.md
IO_UART_IN -- requirements
Module: io_uart_in

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning RX FIFO depth = 2**FIFO_AW bytes.
REQ-002 SHALL have parameter RX_DATA_ADR, default 14'h3E02, meaning word address of the RX data register.
REQ-003 SHALL have parameter RX_STAT_ADR, default 14'h3E03, meaning word address of the RX status/control register.
REQ-004 SHALL have port clk, input, 1, the only clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have ports dma_io_we input 1, dma_io_wadr input [15:2], dma_io_wdata input 32: CPU IO write.
REQ-007 SHALL have ports dma_io_radr input [15:2], dma_io_radr_en input 1: CPU IO read request.
REQ-008 SHALL have port dma_io_rdata_in, input, 32: read data from the next IO block in the chain.
REQ-009 SHALL have port dma_io_rdata, output, 32: chained read data toward the CPU.
REQ-010 SHALL have ports uart_in_char input 8, uart_in_we input 1: one received byte per uart_in_we pulse.
REQ-011 SHALL have port uart_in_full, output, 1: RX FIFO full, combinational from FIFO count.
REQ-012 SHALL have port interrupt_rx, output, 1: level RX interrupt request.

Function
REQ-013 SHALL push uart_in_char into the FIFO on uart_in_we when not full.
REQ-014 SHALL drop the byte on uart_in_we while full and no pop occurs that cycle, setting sticky overrun.
REQ-015 SHALL accept simultaneous push and pop at full: count unchanged, no overrun.
REQ-016 SHALL pop one byte on dma_io_radr_en with dma_io_radr==RX_DATA_ADR when not empty.
REQ-017 SHALL leave pointers unchanged on a data read while empty; that read returns 32'd0.
REQ-018 SHALL wrap read/write pointers modulo 2**FIFO_AW; count SHALL be FIFO_AW+1 bits, range 0..2**FIFO_AW.
REQ-019 SHALL register read data: the cycle after a hit, dma_io_rdata = {24'd0, byte} for data, status word for status.
REQ-020 SHALL drive dma_io_rdata = dma_io_rdata_in in every cycle not following a hit (one-cycle latency for hits).
REQ-021 SHALL define status: bit0 not-empty, bit1 overrun, bit2 irq_enable, bits[12:8] count (zero-extended), others 0.
REQ-022 SHALL, on dma_io_we to RX_STAT_ADR, set irq_enable = wdata[2]; wdata[1]=1 clears overrun.
REQ-023 SHALL give overrun set priority over a same-cycle clear.
REQ-024 SHALL ignore writes to RX_DATA_ADR and all other addresses.
REQ-025 SHALL hold status reads side-effect free; only data reads pop.

Reset
REQ-026 SHALL, on rst, zero pointers, count, overrun, irq_enable, read-hit flag and read register.
REQ-027 SHALL output after reset: dma_io_rdata = dma_io_rdata_in, uart_in_full=0, interrupt_rx=0.
REQ-028 SHALL discard FIFO contents and any push/pop/write asserted in a cycle where rst is high.

Configuration
REQ-029 SHALL, with IO_UART_IN_IRQ_EN defined, drive interrupt_rx = irq_enable & (not-empty | overrun), registered.
REQ-030 SHALL, without IO_UART_IN_IRQ_EN, tie interrupt_rx to 0, omit irq_enable storage, read status bit2 as 0.

Structure
REQ-031 SHALL place default address constants and status bit positions in shared package io_uart_in_pkg.
REQ-032 SHALL implement storage in one sub-module io_rx_fifo (synchronous FIFO, push/pop/full/empty/count).

Verification
REQ-033 SHALL test: push 8'h41, 8'h42; read RX_DATA_ADR twice -> 32'h41 then 32'h42 one cycle after each; status then 32'h0.
REQ-034 SHALL test: 17 pushes at FIFO_AW=4 -> uart_in_full=1 after 16th; 17th dropped; status = 32'h0000_1003.
REQ-035 SHALL test: full FIFO, push+pop same cycle -> count stays 16, overrun 0, popped byte is oldest.
REQ-036 SHALL test: write status 32'h2 with overrun set -> overrun 0; write 32'h2 coincident with dropped push -> overrun stays 1.
REQ-037 SHALL test: read RX_DATA_ADR while empty -> 32'd0, no pointer move; non-hit read with dma_io_rdata_in=32'hDEAD_BEEF -> passes through.
REQ-038 SHALL test (IRQ_EN): write status 32'h4, push one byte -> interrupt_rx=1; pop it -> interrupt_rx=0; rst mid-FIFO -> empty, all outputs per REQ-027.
